// File: rtl/alu_seq_if.sv
//------------------------------------------------------------------------------
// alu_seq_if : operand-side and result-side valid/ready bundle for alu_seq
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             neg;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zero, carry, neg
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zero, carry, neg
   );
endinterface

`default_nettype wire

// File: rtl/alu_seq.sv
//------------------------------------------------------------------------------
// alu_seq : registered ALU, single-cycle logic/arith ops, 1-bit/cycle shifts
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq #(
   parameter int WIDTH = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   alu_seq_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_result;
   logic [SHW-1:0]   r_count;
   logic             r_is_shr;
   logic             r_out_valid;
   logic             r_zero;
   logic             r_carry;
   logic             r_neg;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_cy;
   logic [WIDTH-1:0] w_step;
   logic             w_out_bit;
   logic [SHW-1:0]   w_k;
   logic             w_long_shift;
   logic             w_in_ready;
   logic             w_accept;

   assign w_k          = bus.b[SHW-1:0];
   assign w_long_shift = bus.op[2] && bus.op[1] && (w_k != '0);
   assign w_in_ready   = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
   assign w_accept     = bus.in_valid && w_in_ready;

   // Single-cycle datapath; shifts with k=0 fall through to PASSA behaviour.
   always_comb begin
      w_sum = {1'b0, bus.a} + {1'b0, bus.b};
      w_res = '0;
      w_cy  = 1'b0;
      case (bus.op)
         3'b000: begin
            w_res = w_sum[WIDTH-1:0];
            w_cy  = w_sum[WIDTH];
         end
         3'b001: begin
            w_res = bus.a - bus.b;
            w_cy  = (bus.a < bus.b);
         end
         3'b010:  w_res = bus.a & bus.b;
         3'b011:  w_res = bus.a | bus.b;
         3'b100:  w_res = bus.a ^ bus.b;
         default: w_res = bus.a;
      endcase
   end

   always_comb begin
      w_step    = r_work;
      w_out_bit = 1'b0;
      if (r_is_shr) begin
         w_step    = {1'b0, r_work[WIDTH-1:1]};
         w_out_bit = r_work[0];
      end else begin
         w_step    = {r_work[WIDTH-2:0], 1'b0};
         w_out_bit = r_work[WIDTH-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_work      <= '0;
         r_result    <= '0;
         r_count     <= '0;
         r_is_shr    <= 1'b0;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_neg       <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if ((r_state == DONE) && bus.out_ready && !bus.in_valid) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
               if (w_accept) begin
                  if (w_long_shift) begin
                     r_work      <= bus.a;
                     r_count     <= w_k;
                     r_is_shr    <= bus.op[0];
                     r_out_valid <= 1'b0;
                     r_state     <= SHIFT;
                  end else begin
                     r_result    <= w_res;
                     r_carry     <= w_cy;
                     r_zero      <= (w_res == '0);
                     r_neg       <= w_res[WIDTH-1];
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            SHIFT: begin
               r_work  <= w_step;
               r_carry <= w_out_bit;
               r_count <= r_count - 1'b1;
               if (r_count == SHW'(1)) begin
                  r_result    <= w_step;
                  r_zero      <= (w_step == '0);
                  r_neg       <= w_step[WIDTH-1];
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.carry     = r_carry;
   assign bus.neg       = r_neg;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
//------------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=8)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_seq_if #(.WIDTH(8)) bus ();

   alu_seq #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {out_valid, result, zero, carry, neg}
   function automatic logic [11:0] obs();
      return {bus.out_valid, bus.result, bus.zero, bus.carry, bus.neg};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 12'h000) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected %h", obs(), 12'h000);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_add();
      drive(3'b000, 8'hF0, 8'h20);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'h10, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_F0_20: got %h expected %h", obs(), {1'b1, 8'h10, 1'b0, 1'b1, 1'b0});
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_drain: out_valid=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_sub();
      drive(3'b001, 8'h05, 8'h0A);
      tick();
      checks++;
      if (obs() !== {1'b1, 8'hFB, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_05_0A: got %h expected %h", obs(), {1'b1, 8'hFB, 1'b0, 1'b1, 1'b1});
      end
      drive(3'b001, 8'h0A, 8'h0A);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_0A_0A: got %h expected %h", obs(), {1'b1, 8'h00, 1'b1, 1'b0, 1'b0});
      end
      tick();
   endtask

   task automatic test_shift();
      drive(3'b110, 8'h81, 8'h03);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL shl_busy[%0d]: in_ready=%b out_valid=%b expected 0/0", i, bus.in_ready, bus.out_valid);
         end
         if (i < 2) tick();
      end
      tick();
      checks++;
      if (obs() !== {1'b1, 8'h08, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL shl_81_3: got %h expected %h", obs(), {1'b1, 8'h08, 1'b0, 1'b0, 1'b0});
      end
      tick();
      drive(3'b111, 8'h81, 8'h01);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL shr_early: out_valid=%b expected 0", bus.out_valid);
      end
      tick();
      checks++;
      if (obs() !== {1'b1, 8'h40, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL shr_81_1: got %h expected %h", obs(), {1'b1, 8'h40, 1'b0, 1'b1, 1'b0});
      end
      tick();
      drive(3'b110, 8'hC3, 8'h08);   // k = b[2:0] = 0 -> pass-through
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'hC3, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL shl_k0: got %h expected %h", obs(), {1'b1, 8'hC3, 1'b0, 1'b0, 1'b1});
      end
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      drive(3'b010, 8'h0F, 8'hF0);
      tick();
      drive(3'b000, 8'h01, 8'h01);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (obs() !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0} || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got %h in_ready=%b expected %h in_ready=0", i, obs(), bus.in_ready, {1'b1, 8'h00, 1'b1, 1'b0, 1'b0});
         end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: in_ready=%b expected 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'h02, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL bp_next_op: got %h expected %h", obs(), {1'b1, 8'h02, 1'b0, 1'b0, 1'b0});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drive(3'b100, 8'h0A, 8'h05);
      tick();
      checks++;
      if (obs() !== {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0} || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stream_xor: got %h in_ready=%b expected %h in_ready=1", obs(), bus.in_ready, {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0});
      end
      drive(3'b011, 8'h0A, 8'h05);
      tick();
      checks++;
      if (obs() !== {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL stream_or: got %h expected %h", obs(), {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0});
      end
      drive(3'b101, 8'h80, 8'h3C);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL stream_passa: got %h expected %h", obs(), {1'b1, 8'h80, 1'b0, 1'b0, 1'b1});
      end
      tick();
   endtask

   task automatic test_reset_mid_shift();
      drive(3'b110, 8'hFF, 8'h07);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== 8'h80 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_shift_state: out_valid=%b result=%h in_ready=%b expected 0/80/0", bus.out_valid, bus.result, bus.in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== 12'h000) begin
         errors++;
         $display("FAIL mid_shift_reset: got %h expected %h", obs(), 12'h000);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (obs() !== 12'h000) begin
         errors++;
         $display("FAIL abandoned_op: got %h expected %h", obs(), 12'h000);
      end
      drive(3'b000, 8'h01, 8'h01);
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 8'h02, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL post_reset_add: got %h expected %h", obs(), {1'b1, 8'h02, 1'b0, 1'b0, 1'b0});
      end
      tick();
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      #2;
      test_reset();
      test_add();
      test_sub();
      test_shift();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
